// File: rtl/oreg_display_pkg.sv
// Shared types and constants for the register viewer: debounce FSM states,
// display idle codes and the active-low hex-to-segment table.
package oreg_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_WAIT_PRESS,
    DB_PRESSED,
    DB_WAIT_RELEASE
  } db_state_t;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer plus a press/release debounce FSM.
// Emits a single-cycle step per accepted press; DEBOUNCE_CYC must be >= 2.
module btn_debounce
  import oreg_display_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic step
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          btn;
  db_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic          step_q;

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
  end

  assign btn  = sync_q[1];
  assign step = step_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  // The press is accepted on the edge where the counter reaches CNT_LAST.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        DB_IDLE: begin
          if (btn) begin
            state_q <= DB_WAIT_PRESS;
            cnt_q   <= '0;
          end
        end
        DB_WAIT_PRESS: begin
          if (!btn) begin
            state_q <= DB_IDLE;
          end else if (CW'(cnt_q + 1'b1) == CNT_LAST) begin
            state_q <= DB_PRESSED;
            step_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= CW'(cnt_q + 1'b1);
          end
        end
        DB_PRESSED: begin
          state_q <= DB_WAIT_RELEASE;
          cnt_q   <= '0;
        end
        default: begin
          if (btn) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_IDLE;
          end else begin
            cnt_q <= CW'(cnt_q + 1'b1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/oreg_display.sv
// Seven-segment viewer for the CPU oreg debug bus: button-selected register,
// optional freeze snapshot, 8-digit time-multiplexed hex with dp marking sel.
module oreg_display
  import oreg_display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int NREG         = 5
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [32*NREG-1:0]   oreg,
  input  logic                 btn_next,
  input  logic                 freeze,
  output logic [7:0]           an,
  output logic [7:0]           seg,
  output logic [2:0]           sel
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [2:0]    SEL_LAST  = 3'(NREG - 1);

  logic          step;
  logic [1:0]    frz_sync_q, frz_sync_d;
  logic [2:0]    sel_q, sel_d;
  logic [31:0]   disp_val_q, disp_val_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    nib;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_dbnc (
    .clk_in (clk_in),
    .reset  (reset),
    .btn_raw(btn_next),
    .step   (step)
  );

  always_comb begin
    frz_sync_d = {frz_sync_q[0], freeze};

    sel_d = sel_q;
    if (step) begin
      sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
    end

    disp_val_d = frz_sync_q[1] ? disp_val_q : oreg[{sel_q, 5'b00000} +: 32];

    scan_cnt_d = SW'(scan_cnt_q + 1'b1);
    digit_d    = digit_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 3'd1;
    end

    // Outputs are built from the current digit/snapshot, so they lag one cycle.
    nib   = disp_val_q[{digit_q, 2'b00} +: 4];
    an_d  = ~(8'b0000_0001 << digit_q);
    seg_d = {(digit_q != sel_q), hex_to_seg(nib)};
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      frz_sync_q <= 2'b00;
      sel_q      <= 3'd0;
      disp_val_q <= 32'd0;
      scan_cnt_q <= '0;
      digit_q    <= 3'd0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      frz_sync_q <= frz_sync_d;
      sel_q      <= sel_d;
      disp_val_q <= disp_val_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_oreg_display.sv
// Directed bench for oreg_display with SCAN_DIV=4, DEBOUNCE_CYC=8.
module tb_oreg_display;

  logic         clk_in = 1'b0;
  logic         reset;
  logic [159:0] oreg;
  logic         btn_next;
  logic         freeze;
  logic [7:0]   an;
  logic [7:0]   seg;
  logic [2:0]   sel;

  int checks   = 0;
  int failures = 0;
  int step_cnt = 0;
  int step_before;

  // digit 0..7 of 32'h1234ABCD with sel=0 (dp lit on digit 0 only)
  logic [7:0] exp_abcd [8] = '{8'h21, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  oreg_display #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(8),
    .NREG        (5)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .oreg    (oreg),
    .btn_next(btn_next),
    .freeze  (freeze),
    .an      (an),
    .seg     (seg),
    .sel     (sel)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (dut.step) step_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Waits for a fresh arrival of 'target' on an, bounded to 100 cycles.
  task automatic wait_an(input logic [7:0] target);
    int n = 0;
    while (an == target && n < 100) begin tick(); n++; end
    while (an != target && n < 100) begin tick(); n++; end
    chk("wait_an", {24'd0, an}, {24'd0, target});
  endtask

  task automatic press(input int hi, input int lo);
    btn_next = 1'b1;
    repeat (hi) tick();
    btn_next = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    reset    = 1'b0;
    btn_next = 1'b0;
    freeze   = 1'b0;
    oreg     = '0;
    repeat (5) tick();
    chk("rst_an",  {24'd0, an},  32'hFF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_sel", {29'd0, sel}, 32'd0);

    reset = 1'b1;
    tick();
    chk("first_an",  {24'd0, an},  32'hFE);
    chk("first_seg", {24'd0, seg}, 32'h40);

    // Scan sequence and decode of 1234ABCD
    oreg[31:0] = 32'h1234ABCD;
    wait_an(8'hFE);
    for (int k = 0; k < 9; k++) begin
      chk("scan_an", {24'd0, an}, {24'd0, ~(8'd1 << (k % 8))});
      if (k < 8) chk("scan_seg", {24'd0, seg}, {24'd0, exp_abcd[k]});
      repeat (4) tick();
    end

    // Short bounces must not step
    press(3, 6);
    press(3, 6);
    press(3, 6);
    chk("bounce_sel", {29'd0, sel}, 32'd0);

    // Clean 20-cycle press: sel moves on the 11th edge after the raw rise
    btn_next = 1'b1;
    repeat (10) tick();
    chk("lat_before", {29'd0, sel}, 32'd0);
    tick();
    chk("lat_after", {29'd0, sel}, 32'd1);
    repeat (9) tick();
    btn_next = 1'b0;
    repeat (15) tick();
    chk("held_once", {29'd0, sel}, 32'd1);

    // Release glitch shorter than the debounce window does not re-arm
    btn_next = 1'b1;
    repeat (20) tick();
    btn_next = 1'b0;
    repeat (3) tick();
    btn_next = 1'b1;
    repeat (10) tick();
    btn_next = 1'b0;
    repeat (15) tick();
    chk("glitch_sel", {29'd0, sel}, 32'd2);

    press(12, 15);
    chk("sel3", {29'd0, sel}, 32'd3);
    press(12, 15);
    chk("sel4", {29'd0, sel}, 32'd4);
    press(12, 15);
    chk("sel_wrap", {29'd0, sel}, 32'd0);
    press(12, 15);
    chk("sel1", {29'd0, sel}, 32'd1);

    // Freeze holds the snapshot of register 1
    oreg[63:32] = 32'h0000000F;
    repeat (3) tick();
    freeze = 1'b1;
    repeat (4) tick();
    oreg[63:32] = 32'hFFFFFFFF;
    wait_an(8'hFE);
    chk("frz_d0", {24'd0, seg}, 32'h8E);
    repeat (4) tick();
    chk("frz_an1", {24'd0, an}, 32'hFD);
    chk("frz_d1", {24'd0, seg}, 32'h40);
    freeze = 1'b0;
    repeat (2) tick();
    chk("unfrz_hold", dut.disp_val_q, 32'h0000000F);
    tick();
    chk("unfrz_load", dut.disp_val_q, 32'hFFFFFFFF);
    wait_an(8'hFE);
    chk("unfrz_d0", {24'd0, seg}, 32'h8E);
    repeat (4) tick();
    chk("unfrz_d1", {24'd0, seg}, 32'h0E);
    repeat (4) tick();
    chk("unfrz_d2", {24'd0, seg}, 32'h8E);

    // Reset during WAIT_PRESS, then release: no step afterwards
    btn_next = 1'b1;
    repeat (6) tick();
    reset = 1'b0;
    #1;
    chk("midrst_sel", {29'd0, sel}, 32'd0);
    chk("midrst_an",  {24'd0, an},  32'hFF);
    chk("midrst_seg", {24'd0, seg}, 32'hFF);
    tick();
    btn_next    = 1'b0;
    reset       = 1'b1;
    step_before = step_cnt;
    repeat (25) tick();
    chk("midrst_nostep", step_cnt - step_before, 32'd0);
    chk("midrst_sel2", {29'd0, sel}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
